logic_unit_pipe: RTL and testbench
==================================

Name: logic_unit_pipe

Overview:
- Parametrised, registered successor to the team's fixed 1-bit AND/OR/XOR top-level.
- One WIDTH-bit bitwise logic unit with run-time op select, an optional accumulate mode, and a valid/ready handshake on input and output.
- One-stage pipeline with backpressure, plus a transaction counter.
- Sits between operand sources and downstream consumers in lab datapaths.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1).
- CNT_W, 16, width of completed-transaction counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  operand set present.
- in_ready  output  1  unit can accept this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B (ignored when acc_en=1).
- op  input  2  00 AND, 01 OR, 10 XOR, 11 XNOR.
- acc_en  input  1  1: result = op(acc, a); 0: result = op(a, b).
- acc_clr  input  1  clear accumulator.
- out_valid  output  1  result register holds valid data.
- out_ready  input  1  downstream accepts result.
- out_data  output  WIDTH  registered result.
- acc_q  output  WIDTH  current accumulator value.
- txn_cnt  output  CNT_W  count of completed output handshakes.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high. All state changes on the rising edge of clk.
- Reset (rst=1 at the edge): out_valid=0, out_data=0, acc_q=0, txn_cnt=0. in_ready is forced 0 while rst=1. rst overrides every other input, including mid-transaction; a pending result is discarded.
- in_ready = !out_valid || out_ready (combinational, no extra register).
- Accept = in_valid && in_ready. Output handshake = out_valid && out_ready.
- Latency: the result is visible on out_data with out_valid=1 exactly 1 cycle after accept.
- Throughput: one transaction per cycle when out_ready is held high.
- Stall: while out_valid=1 and out_ready=0, out_data, out_valid and acc_q hold stable. The input is not accepted.
- Output update: on accept, out_data <= result and out_valid <= 1.
  - Output handshake without accept: out_valid <= 0, out_data holds its last value.
  - Both in the same cycle: new result loaded, out_valid stays 1.
- Accumulator:
  - On accept with acc_en=1: acc_q <= result.
  - On accept with acc_en=0: acc_q unchanged.
  - acc_clr=1 without accept: acc_q <= 0.
  - acc_clr=1 with an acc_en=1 accept: the operation uses acc=0 (clear applies first), then acc_q <= op(0, a).
  - acc_clr=1 with an acc_en=0 accept: result = op(a, b), acc_q <= 0.
- txn_cnt increments by 1 on each output handshake and wraps from 2^CNT_W-1 to 0.
- All bitwise operations are WIDTH-wide. No carries, no sign handling.
- in_valid deasserting while in_ready=0 is legal; nothing is captured.

Optional Feature:
- Macro: LOGIC_UNIT_POPCOUNT_EN.
- Defined: adds output port out_ones, width $clog2(WIDTH+1), equal to the number of 1 bits in the result.
  - Registered alongside out_data with identical latency and stall behaviour.
  - Reset value 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package logic_unit_pkg holds:
  - op encodings: OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_XNOR=2'b11;
  - the op field width constant.
- Sub-module logic_op: purely combinational, WIDTH-parametrised. Inputs x, y, op; output f. Replaces the separate per-gate modules.
- logic_unit_pipe instantiates one logic_op. Its x input is muxed between a and the (cleared) accumulator.

Test Plan:
- WIDTH=8, out_ready=1; a=8'hF0, b=8'h3C through ops 00..11 on consecutive cycles -> out_data 8'h30, 8'hFC, 8'hCC, 8'h33, each 1 cycle after accept; txn_cnt=4.
- Accumulate: acc_clr=1 with acc_en=1, op=XOR, a=8'h0F; then a=8'hFF -> out_data 8'h0F then 8'hF0; acc_q=8'hF0.
- Backpressure: out_ready=0 for 3 cycles with a result pending -> in_ready=0, out_data and acc_q stable, txn_cnt unchanged. Raise out_ready with a new input the same cycle -> new result next cycle, out_valid stays 1.
- Reset mid-stall: rst=1 while out_valid=1 -> next cycle out_valid=0, out_data=0, acc_q=0, txn_cnt=0, in_ready=0 during rst.
- Counter wrap: CNT_W=4, 17 handshakes -> txn_cnt=1.
- With LOGIC_UNIT_POPCOUNT_EN: a=8'hFF, b=8'h0F, op=AND -> out_data=8'h0F, out_ones=4 in the same cycle.

Source files
------------

// File: rtl/logic_unit_pipe_pkg.sv
// rtl/logic_unit_pipe_pkg.sv - op encodings and shared constants for the logic unit pipe
package logic_unit_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_XNOR = 2'b11
  } op_e;

endpackage

// File: rtl/logic_unit_pipe_if.sv
// rtl/logic_unit_pipe_if.sv - operand/result handshake bundle; out_ones present under LOGIC_UNIT_POPCOUNT_EN
interface logic_unit_pipe_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  import logic_unit_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [OP_W-1:0]  op;
  logic             acc_en;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [WIDTH-1:0] acc_q;
  logic [CNT_W-1:0] txn_cnt;

`ifdef LOGIC_UNIT_POPCOUNT_EN
  logic [$clog2(WIDTH+1)-1:0] out_ones;

  modport master (
    output in_valid, a, b, op, acc_en, acc_clr, out_ready,
    input  in_ready, out_valid, out_data, acc_q, txn_cnt, out_ones
  );

  modport slave (
    input  in_valid, a, b, op, acc_en, acc_clr, out_ready,
    output in_ready, out_valid, out_data, acc_q, txn_cnt, out_ones
  );
`else
  modport master (
    output in_valid, a, b, op, acc_en, acc_clr, out_ready,
    input  in_ready, out_valid, out_data, acc_q, txn_cnt
  );

  modport slave (
    input  in_valid, a, b, op, acc_en, acc_clr, out_ready,
    output in_ready, out_valid, out_data, acc_q, txn_cnt
  );
`endif

endinterface

// File: rtl/logic_unit_pipe_logic_op.sv
// rtl/logic_unit_pipe_logic_op.sv - combinational WIDTH-wide AND/OR/XOR/XNOR selected by op
module logic_op
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] f
);

  always_comb begin
    f = '0;
    case (op)
      OP_AND:  f = x & y;
      OP_OR:   f = x | y;
      OP_XOR:  f = x ^ y;
      default: f = ~(x ^ y);
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - registered logic unit with accumulator, backpressure and txn counter
// Optional popcount output enabled by defining LOGIC_UNIT_POPCOUNT_EN.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input logic              clk,
  input logic              rst,
  logic_unit_pipe_if.slave bus
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] acc_q_q, acc_q_d;
  logic [CNT_W-1:0] txn_cnt_q, txn_cnt_d;

  logic             in_ready;
  logic             accept;
  logic             out_hs;
  logic [WIDTH-1:0] acc_eff;
  logic [WIDTH-1:0] op_x;
  logic [WIDTH-1:0] op_y;
  logic [WIDTH-1:0] result;

  assign in_ready = !rst && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign out_hs   = out_valid_q && bus.out_ready;

  // A same-cycle clear is seen by the operation before the accumulator is read.
  assign acc_eff = bus.acc_clr ? '0 : acc_q_q;
  assign op_x    = bus.acc_en ? acc_eff : bus.a;
  assign op_y    = bus.acc_en ? bus.a   : bus.b;

  logic_op #(.WIDTH(WIDTH)) u_logic_op (
    .x  (op_x),
    .y  (op_y),
    .op (bus.op),
    .f  (result)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    acc_q_d     = acc_eff;
    txn_cnt_d   = txn_cnt_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = result;
      if (bus.acc_en) begin
        acc_q_d = result;
      end
    end else if (out_hs) begin
      out_valid_d = 1'b0;
    end
    if (out_hs) begin
      txn_cnt_d = txn_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      acc_q_q     <= '0;
      txn_cnt_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      acc_q_q     <= acc_q_d;
      txn_cnt_q   <= txn_cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.acc_q     = acc_q_q;
  assign bus.txn_cnt   = txn_cnt_q;

`ifdef LOGIC_UNIT_POPCOUNT_EN
  localparam int ONES_W = $clog2(WIDTH + 1);

  logic [ONES_W-1:0] ones_q, ones_d, result_ones;

  always_comb begin
    result_ones = '0;
    for (int i = 0; i < WIDTH; i++) begin
      result_ones = result_ones + ONES_W'(result[i]);
    end
  end

  assign ones_d = accept ? result_ones : ones_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ones_q <= '0;
    end else begin
      ones_q <= ones_d;
    end
  end

  assign bus.out_ones = ones_q;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb/tb_logic_unit_pipe.sv - directed self-checking bench for logic_unit_pipe
module tb_logic_unit_pipe;

  logic clk;
  logic rst;
  logic rst4;
  int   tests;
  int   fails;

  logic_unit_pipe_if #(.WIDTH(8), .CNT_W(16)) bus ();
  logic_unit_pipe_if #(.WIDTH(8), .CNT_W(4))  bus4 ();

  logic_unit_pipe #(.WIDTH(8), .CNT_W(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic_unit_pipe #(.WIDTH(8), .CNT_W(4)) u_dut4 (
    .clk (clk),
    .rst (rst4),
    .bus (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] op, input logic acc_en, input logic acc_clr);
    bus.in_valid = v;
    bus.a        = a;
    bus.b        = b;
    bus.op       = op;
    bus.acc_en   = acc_en;
    bus.acc_clr  = acc_clr;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    rst4  = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0);
    bus.out_ready  = 1'b1;
    bus4.in_valid  = 1'b0;
    bus4.a         = 8'h5A;
    bus4.b         = 8'hFF;
    bus4.op        = 2'b00;
    bus4.acc_en    = 1'b0;
    bus4.acc_clr   = 1'b0;
    bus4.out_ready = 1'b1;

    tick();
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_acc_q", bus.acc_q, 0);
    check("rst_txn_cnt", bus.txn_cnt, 0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", bus.in_ready, 1);

    drive(1'b1, 8'hF0, 8'h3C, 2'b00, 1'b0, 1'b0);
    tick();
    check("and_valid", bus.out_valid, 1);
    check("and_data", bus.out_data, 8'h30);
    bus.op = 2'b01;
    tick();
    check("or_data", bus.out_data, 8'hFC);
    bus.op = 2'b10;
    tick();
    check("xor_data", bus.out_data, 8'hCC);
    bus.op = 2'b11;
    tick();
    check("xnor_data", bus.out_data, 8'h33);
    check("xnor_valid", bus.out_valid, 1);
    bus.in_valid = 1'b0;
    tick();
    check("drain_valid", bus.out_valid, 0);
    check("drain_data_hold", bus.out_data, 8'h33);
    check("ops_txn_cnt", bus.txn_cnt, 4);
    check("ops_acc_untouched", bus.acc_q, 0);

    drive(1'b1, 8'h0F, 8'h00, 2'b10, 1'b1, 1'b1);
    tick();
    check("acc1_data", bus.out_data, 8'h0F);
    check("acc1_acc_q", bus.acc_q, 8'h0F);
    drive(1'b1, 8'hFF, 8'h00, 2'b10, 1'b1, 1'b0);
    tick();
    check("acc2_data", bus.out_data, 8'hF0);
    check("acc2_acc_q", bus.acc_q, 8'hF0);
    check("acc2_txn_cnt", bus.txn_cnt, 5);

    drive(1'b1, 8'hAA, 8'h0F, 2'b00, 1'b0, 1'b0);
    bus.out_ready = 1'b0;
    #1;
    check("stall_in_ready", bus.in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_valid", bus.out_valid, 1);
      check("stall_data", bus.out_data, 8'hF0);
      check("stall_acc_q", bus.acc_q, 8'hF0);
      check("stall_txn_cnt", bus.txn_cnt, 5);
      check("stall_in_ready_hold", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    #1;
    check("release_in_ready", bus.in_ready, 1);
    tick();
    check("release_valid", bus.out_valid, 1);
    check("release_data", bus.out_data, 8'h0A);
    check("release_acc_q", bus.acc_q, 8'hF0);
    check("release_txn_cnt", bus.txn_cnt, 6);

    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    tick();
    check("pre_rst_valid", bus.out_valid, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_in_ready", bus.in_ready, 0);
    tick();
    check("rst_mid_valid", bus.out_valid, 0);
    check("rst_mid_data", bus.out_data, 0);
    check("rst_mid_acc_q", bus.acc_q, 0);
    check("rst_mid_txn_cnt", bus.txn_cnt, 0);
    rst = 1'b0;
    bus.out_ready = 1'b1;

`ifdef LOGIC_UNIT_POPCOUNT_EN
    drive(1'b1, 8'hFF, 8'h0F, 2'b00, 1'b0, 1'b0);
    tick();
    check("pop_data", bus.out_data, 8'h0F);
    check("pop_ones", bus.out_ones, 4);
    bus.in_valid = 1'b0;
    tick();
`endif

    rst4 = 1'b0;
    bus4.in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      tick();
    end
    bus4.in_valid = 1'b0;
    tick();
    check("wrap_txn_cnt", bus4.txn_cnt, 1);
    check("wrap_valid", bus4.out_valid, 0);
    check("wrap_data", bus4.out_data, 8'h5A);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
